fu_issue_scheduler: RTL

FU_ISSUE_SCHEDULER -- requirements
Module: fu_issue_scheduler

---
 rtl/fu_issue_scheduler_pkg.sv | 26 ++
 rtl/fu_issue_scheduler_rr_picker.sv | 41 ++++
 rtl/fu_issue_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fu_issue_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module      : RSTableROBStruct (package)
// Description : Shared types and constants for the FU issue scheduler.
//               Holds the per-FU state type and the functional unit count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package RSTableROBStruct;

    // Number of functional units fed by the scheduler: FU0/FU1 are ALUs, FU2 is the LSU
    localparam int FU_COUNT = 3;

    // Width of the per-FU execute down-counter (latencies 1..15)
    localparam int CNT_W = 4;

    // Per-FU lifecycle: waiting for work, executing, holding a result for writeback
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } fu_state_t;

endpackage

`default_nettype wire

// File: rtl/fu_issue_scheduler_rr_picker.sv
//------------------------------------------------------------------------------
// Module      : rr_picker
// Description : Combinational find-first-set starting at a pointer, wrapping
//               from WIDTH-1 back to 0. Returns whether anything matched and
//               the index of the first match.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
    parameter  int WIDTH = 64,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int w_pos;

    // Walk WIDTH positions starting at ptr; the first requester wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = 0;
        for (int k = 0; k < WIDTH; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= WIDTH) begin
                w_pos = w_pos - WIDTH;
            end
            if (!found && req[w_pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fu_issue_scheduler.sv
//------------------------------------------------------------------------------
// Module      : fu_issue_scheduler
// Description : Issues ready reservation-station rows to three functional
//               units (two ALUs, one LSU) with per-FU round-robin row
//               selection, tracks each FU through IDLE/EXEC/WB and arbitrates
//               a single writeback port round-robin.
//               Build option FU_BACK_TO_BACK_EN: an FU granted writeback may
//               accept a new issue in the same cycle (WB->EXEC directly).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fu_issue_scheduler
    import RSTableROBStruct::*;
#(
    parameter  int RS_ROW_COUNT = 64,
    parameter  int ALU_LAT      = 1,
    parameter  int LSU_LAT      = 3,
    localparam int ROW_W        = $clog2(RS_ROW_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [RS_ROW_COUNT-1:0]     row_req,
    input  logic [2*RS_ROW_COUNT-1:0]   row_fu,
    output logic [FU_COUNT-1:0]         issue_valid,
    output logic [FU_COUNT*ROW_W-1:0]   issue_row,
    output logic [FU_COUNT-1:0]         fu_ready,
    output logic                        wb_valid,
    output logic [1:0]                  wb_fu
);

    // Issue and writeback are both suppressed while in reset or flushing
    logic                w_run;
    logic [FU_COUNT-1:0] w_wb_req;
    logic [FU_COUNT-1:0] w_grant;
    logic                w_wb_found;
    logic [1:0]          w_wb_idx;
    logic                w_wb_fire;
    logic [1:0]          r_wb_ptr;

    assign w_run = rst_n & ~flush;

    rr_picker #(
        .WIDTH (FU_COUNT)
    ) u_wb_pick (
        .req   (w_wb_req),
        .ptr   (r_wb_ptr),
        .found (w_wb_found),
        .idx   (w_wb_idx)
    );

    assign w_wb_fire = w_run & w_wb_found;
    assign wb_valid  = w_wb_fire;
    assign wb_fu     = w_wb_fire ? w_wb_idx : 2'd0;

    // Writeback pointer advances past each grantee; flush leaves it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_ptr <= 2'd0;
        end else if (w_wb_fire) begin
            r_wb_ptr <= (w_wb_idx == 2'(FU_COUNT - 1)) ? 2'd0 : w_wb_idx + 2'd1;
        end
    end

    for (genvar f = 0; f < FU_COUNT; f++) begin : g_fu
        localparam int               c_LAT  = (f == 2) ? LSU_LAT : ALU_LAT;
        localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(c_LAT - 1);

        fu_state_t               r_state;
        fu_state_t               w_state_nxt;
        logic [CNT_W-1:0]        r_cnt;
        logic [CNT_W-1:0]        w_cnt_nxt;
        logic [ROW_W-1:0]        r_rr_ptr;
        logic [RS_ROW_COUNT-1:0] w_row_req;
        logic                    w_found;
        logic [ROW_W-1:0]        w_idx;
        logic                    w_free;
        logic                    w_issue;

        // Rows targeting this FU; encoding 3 never matches any FU
        for (genvar i = 0; i < RS_ROW_COUNT; i++) begin : g_row
            assign w_row_req[i] = row_req[i] & (row_fu[2*i +: 2] == 2'(f));
        end

        rr_picker #(
            .WIDTH (RS_ROW_COUNT)
        ) u_row_pick (
            .req   (w_row_req),
            .ptr   (r_rr_ptr),
            .found (w_found),
            .idx   (w_idx)
        );

        assign w_wb_req[f] = (r_state == WB);
        assign w_grant[f]  = w_wb_fire & (w_wb_idx == 2'(f));

`ifdef FU_BACK_TO_BACK_EN
        assign w_free = (r_state == IDLE) | ((r_state == WB) & w_grant[f]);
`else
        assign w_free = (r_state == IDLE);
`endif

        assign w_issue                   = w_free & w_run & w_found;
        assign issue_valid[f]            = w_issue;
        assign issue_row[f*ROW_W +: ROW_W] = w_issue ? w_idx : '0;
        assign fu_ready[f]               = (r_state == IDLE);

        // FU state, execute counter and row pointer registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_rr_ptr <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_issue) begin
                    r_rr_ptr <= (w_idx == ROW_W'(RS_ROW_COUNT - 1)) ? '0 : w_idx + ROW_W'(1);
                end
            end
        end

        // Next-state: issue starts EXEC, counter expiry enters WB, grant leaves WB
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            if (flush) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_issue) begin
                            w_state_nxt = EXEC;
                            w_cnt_nxt   = c_LOAD;
                        end
                    end
                    EXEC: begin
                        if (r_cnt == '0) begin
                            w_state_nxt = WB;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                    WB: begin
                        if (w_grant[f]) begin
                            if (w_issue) begin
                                w_state_nxt = EXEC;
                                w_cnt_nxt   = c_LOAD;
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
